// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: keys an external 256-byte S box with a 3-byte key, then XORs
// a length-prefixed plaintext buffer into a length-prefixed ciphertext buffer.
module arc4_encrypt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
  input  logic [7:0]  s_rddata,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren
);
  localparam int unsigned BW = 8;
  localparam int unsigned KW = 24;
  localparam int unsigned CW = 9;

  typedef enum logic [3:0] {
    IDLE, INIT, KSA_RDI, KSA_RDJ, KSA_WR, LEN,
    PRGA_RDI, PRGA_RDJ, PRGA_WR, PRGA_PAD, PRGA_OUT, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, len_q, len_d;
  logic [CW-1:0] k_q, k_d;
  logic [KW-1:0] key_q, key_d;
  logic [1:0]    km_q, km_d;
  logic          ph_q, ph_d;
  logic          rdy_q, rdy_d;
  logic [BW-1:0] key_byte, j_sum;
  logic          s_wren_c, ct_wren_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      len_q   <= '0;
      k_q     <= '0;
      key_q   <= '0;
      km_q    <= '0;
      ph_q    <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      len_q   <= len_d;
      k_q     <= k_d;
      key_q   <= key_d;
      km_q    <= km_d;
      ph_q    <= ph_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    case (km_q)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      default: key_byte = key_q[7:0];
    endcase
  end

  // Memory ports are decoded from the current state so each read returns on the
  // very next cycle; this is what keeps KSA at four cycles per byte.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    len_d     = len_q;
    k_d       = k_q;
    key_d     = key_q;
    km_d      = km_q;
    ph_d      = ph_q;
    j_sum     = j_q + s_rddata;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren_c  = 1'b0;
    pt_addr   = '0;
    ct_addr   = '0;
    ct_wrdata = '0;
    ct_wren_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          key_d   = key;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          len_d   = '0;
          km_d    = '0;
          ph_d    = 1'b0;
          state_d = INIT;
        end
      end
      INIT: begin
        s_addr   = i_q;
        s_wrdata = i_q;
        s_wren_c = 1'b1;
        i_d      = i_q + BW'(1);
        if (i_q == '1) state_d = KSA_RDI;
      end
      KSA_RDI: begin
        s_addr  = i_q;
        state_d = KSA_RDJ;
      end
      KSA_RDJ: begin
        j_sum   = j_q + s_rddata + key_byte;
        s_addr  = j_sum;
        j_d     = j_sum;
        si_d    = s_rddata;
        state_d = KSA_WR;
      end
      KSA_WR: begin
        s_wren_c = 1'b1;
        if (!ph_q) begin
          s_addr   = i_q;
          s_wrdata = s_rddata;
          ph_d     = 1'b1;
        end else begin
          s_addr   = j_q;
          s_wrdata = si_q;
          ph_d     = 1'b0;
          i_d      = i_q + BW'(1);
          km_d     = (km_q == 2'd2) ? 2'd0 : km_q + 2'd1;
          state_d  = (i_q == '1) ? LEN : KSA_RDI;
        end
      end
      // pt_addr has idled at 0, so pt_rddata already carries the length byte.
      LEN: begin
        len_d     = pt_rddata;
        ct_wrdata = pt_rddata;
        ct_wren_c = 1'b1;
        i_d       = '0;
        j_d       = '0;
        k_d       = CW'(1);
        state_d   = (pt_rddata == '0) ? DONE : PRGA_RDI;
      end
      PRGA_RDI: begin
        pt_addr = k_q[BW-1:0];
        s_addr  = i_q + BW'(1);
        i_d     = i_q + BW'(1);
        state_d = PRGA_RDJ;
      end
      PRGA_RDJ: begin
        pt_addr = k_q[BW-1:0];
        s_addr  = j_sum;
        j_d     = j_sum;
        si_d    = s_rddata;
        state_d = PRGA_WR;
      end
      PRGA_WR: begin
        pt_addr  = k_q[BW-1:0];
        s_wren_c = 1'b1;
        if (!ph_q) begin
          s_addr   = i_q;
          s_wrdata = s_rddata;
          sj_d     = s_rddata;
          ph_d     = 1'b1;
        end else begin
          s_addr   = j_q;
          s_wrdata = si_q;
          ph_d     = 1'b0;
          state_d  = PRGA_PAD;
        end
      end
      PRGA_PAD: begin
        pt_addr = k_q[BW-1:0];
        s_addr  = si_q + sj_q;
        state_d = PRGA_OUT;
      end
      PRGA_OUT: begin
        pt_addr   = k_q[BW-1:0];
        ct_addr   = k_q[BW-1:0];
        ct_wrdata = pt_rddata ^ s_rddata;
        ct_wren_c = 1'b1;
        k_d       = k_q + CW'(1);
        state_d   = (k_q == {1'b0, len_q}) ? DONE : PRGA_RDI;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  // A reset cycle must not commit any write still on the bus.
  assign s_wren  = s_wren_c & ~rst;
  assign ct_wren = ct_wren_c & ~rst;
  assign rdy     = rdy_q;

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: memory models, plain RC4 reference, per-cycle
// ciphertext write scoreboard and directed/random runs.
`timescale 1ns/1ps
module tb_arc4_encrypt;
  logic        clk = 1'b0;
  logic        rst, en, rdy;
  logic [23:0] key;
  logic [7:0]  s_addr, s_wrdata, s_rddata, pt_addr, pt_rddata;
  logic [7:0]  ct_addr, ct_wrdata;
  logic        s_wren, ct_wren;

  arc4_encrypt dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];

  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    pt_rddata <= pt_mem[pt_addr];
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference RC4 on plain arrays.
  logic [7:0] m_s [256];
  logic [7:0] exp_ct [256];
  logic [7:0] exp_ksa [256];
  logic [7:0] exp_fin [256];

  function automatic logic [7:0] kb(input logic [23:0] k, input int n);
    case (n)
      0:       return k[23:16];
      1:       return k[15:8];
      default: return k[7:0];
    endcase
  endfunction

  task automatic model(input logic [23:0] k);
    int jj, ii, L;
    logic [7:0] tmp;
    for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(m_s[x]) + int'(kb(k, x % 3))) % 256;
      tmp = m_s[x]; m_s[x] = m_s[jj]; m_s[jj] = tmp;
    end
    for (int x = 0; x < 256; x++) exp_ksa[x] = m_s[x];
    L = int'(pt_mem[0]);
    exp_ct[0] = pt_mem[0];
    ii = 0; jj = 0;
    for (int n = 1; n <= L; n++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(m_s[ii])) % 256;
      tmp = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = tmp;
      exp_ct[n] = pt_mem[n] ^ m_s[(int'(m_s[ii]) + int'(m_s[jj])) % 256];
    end
    for (int x = 0; x < 256; x++) exp_fin[x] = m_s[x];
  endtask

  // Scoreboard of ciphertext writes, checked every cycle.
  int         exp_addr_q [$];
  logic [7:0] exp_data_q [$];
  int         ct_wr_cnt = 0;

  always @(negedge clk) begin
    if (ct_wren) begin
      ct_wr_cnt++;
      if (exp_addr_q.size() == 0) begin
        check("ct_write_unexpected", 32'(ct_addr), 32'hFFFF);
      end else begin
        int ea;
        logic [7:0] ed;
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        check("ct_addr", 32'(ct_addr), 32'(ea));
        check("ct_wrdata", 32'(ct_wrdata), 32'(ed));
        if (ea == 0) begin
          int d;
          d = 0;
          for (int x = 0; x < 256; x++) if (s_mem[x] !== exp_ksa[x]) d++;
          check("s_after_ksa_diffs", 32'(d), 32'd0);
        end
      end
    end
    if (rdy === 1'b1) check("idle_quiet", 32'({s_wren, ct_wren}), 32'd0);
  end

  task automatic load_plaintext();
    string s;
    s = "Plaintext";
    pt_mem[0] = 8'd9;
    for (int n = 0; n < 9; n++) pt_mem[n + 1] = s[n];
  endtask

  task automatic load_random(input int L);
    pt_mem[0] = 8'(L);
    for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
  endtask

  task automatic arm(input logic [23:0] k);
    model(k);
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int n = 0; n <= int'(pt_mem[0]); n++) begin
      exp_addr_q.push_back(n);
      exp_data_q.push_back(exp_ct[n]);
    end
    ct_wr_cnt = 0;
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    key = 24'($urandom);
    check("rdy_drop", 32'(rdy), 32'd0);
  endtask

  task automatic run(input logic [23:0] k, input bit spam);
    int L, cyc, bound, d;
    arm(k);
    L = int'(pt_mem[0]);
    bound = 256 + 256 * 4 + 2 + L * 6 + 4;
    cyc = 1;
    while (rdy !== 1'b1 && cyc <= bound + 8) begin
      en = spam;
      if (spam) key = 24'($urandom);
      @(negedge clk);
      cyc++;
    end
    en = 1'b0;
    check("latency_in_bound", 32'(cyc <= bound), 32'd1);
    if (rdy !== 1'b1) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    check("ct_write_count", 32'(ct_wr_cnt), 32'(L + 1));
    d = 0;
    for (int n = 0; n <= L; n++) if (ct_mem[n] !== exp_ct[n]) d++;
    check("ct_mem_diffs", 32'(d), 32'd0);
    d = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== exp_fin[x]) d++;
    check("s_final_diffs", 32'(d), 32'd0);
  endtask

  task automatic check_golden(input string nm, input bit use_dut);
    logic [7:0] golden [10];
    int d;
    golden = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    d = 0;
    for (int n = 0; n < 10; n++)
      if ((use_dut ? ct_mem[n] : exp_ct[n]) !== golden[n]) d++;
    check(nm, 32'(d), 32'd0);
  endtask

  logic [7:0] orig [256];

  initial begin
    int guard, d, L;
    rst = 1'b1;
    en  = 1'b1;
    key = 24'hABCDEF;
    repeat (2) @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_s_wren", 32'(s_wren), 32'd0);
    check("rst_ct_wren", 32'(ct_wren), 32'd0);
    check("rst_s_addr", 32'(s_addr), 32'd0);
    check("rst_pt_addr", 32'(pt_addr), 32'd0);
    check("rst_ct_addr", 32'(ct_addr), 32'd0);
    check("rst_s_wrdata", 32'(s_wrdata), 32'd0);
    check("rst_ct_wrdata", 32'(ct_wrdata), 32'd0);
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    check("en_during_rst_ignored", 32'(rdy), 32'd1);

    // Known-answer vector; the model itself is pinned against the literal.
    load_plaintext();
    model(24'h4B6579);
    check_golden("model_golden", 1'b0);
    run(24'h4B6579, 1'b0);
    check_golden("dut_golden", 1'b1);

    // Empty message.
    pt_mem[0] = 8'd0;
    run(24'($urandom), 1'b0);
    check("len0_ct0", 32'(ct_mem[0]), 32'd0);

    // en hammered with fresh keys throughout a run.
    load_plaintext();
    run(24'h4B6579, 1'b1);
    check_golden("spam_golden", 1'b1);

    // Reset in the middle of PRGA, then a clean rerun.
    load_plaintext();
    arm(24'h4B6579);
    guard = 0;
    while (ct_wr_cnt < 4 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("reached_prga", 32'(ct_wr_cnt >= 4), 32'd1);
    #1 rst = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    check("abort_rdy", 32'(rdy), 32'd1);
    check("abort_wren", 32'({s_wren, ct_wren}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_quiet", 32'({s_wren, ct_wren}), 32'd0);
    run(24'h4B6579, 1'b0);
    check_golden("post_abort_golden", 1'b1);

    // Round trip through a full-length buffer.
    load_random(255);
    for (int n = 0; n < 256; n++) orig[n] = pt_mem[n];
    run(24'h1E4600, 1'b0);
    for (int n = 0; n < 256; n++) pt_mem[n] = ct_mem[n];
    run(24'h1E4600, 1'b0);
    d = 0;
    for (int n = 0; n < 256; n++) if (ct_mem[n] !== orig[n]) d++;
    check("round_trip_diffs", 32'(d), 32'd0);

    // Random keys and lengths, including the extremes.
    for (int r = 0; r < 4; r++) begin
      case (r)
        0:       L = 1;
        1:       L = 255;
        default: L = int'($urandom_range(2, 254));
      endcase
      load_random(L);
      run(24'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arc4_encrypt.md
ARC4_ENCRYPT -- requirements
Module: arc4_encrypt

Interface
REQ-001 The block SHALL have no parameters; key length is fixed at 3 bytes and the S, plaintext and ciphertext memories are fixed at 256 x 8.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 en  input  1  start request; honoured only while rdy=1.
REQ-006 rdy  output  1  high when idle and able to accept en.
REQ-007 key  input  24  key; key[23:16] is byte 0, key[15:8] is byte 1, key[7:0] is byte 2.
REQ-008 s_addr / s_wrdata / s_wren  output  8/8/1  port to the external S memory.
REQ-009 s_rddata  input  8  S memory read data, valid 1 cycle after s_addr is presented.
REQ-010 pt_addr  output  8  address into the plaintext memory.
REQ-011 pt_rddata  input  8  plaintext read data, 1-cycle latency; memory is length-prefixed (byte 0 = length L).
REQ-012 ct_addr / ct_wrdata / ct_wren  output  8/8/1  write port to the ciphertext memory.

Function
REQ-013 On en=1 while rdy=1, the block SHALL latch key, drop rdy on the next cycle and begin INIT.
REQ-014 en asserted while rdy=0 SHALL be ignored. Key changes after the latch SHALL have no effect.
REQ-015 States SHALL be: IDLE, INIT, KSA_RDI, KSA_RDJ, KSA_WR, LEN, PRGA_RDI, PRGA_RDJ, PRGA_WR, PRGA_PAD, PRGA_OUT, DONE.
REQ-016 INIT SHALL write S[i]=i for i=0..255, one write per cycle.
REQ-017 KSA SHALL, for i=0..255 with j starting at 0, compute j=(j+S[i]+key[i mod 3]) mod 256, then swap S[i] and S[j]. The two writes SHALL occur on consecutive cycles.
REQ-018 LEN SHALL read pt[0]=L, write ct[0]=L, and hold L in an internal register.
REQ-019 If L=0, the block SHALL go directly to DONE. Otherwise it SHALL run PRGA for k=1..L with i=j=0 at entry.
REQ-020 Each PRGA step SHALL do the following in order:
- i=i+1
- j=j+S[i]
- swap S[i] and S[j]
- pad=S[(S[i]+S[j]) mod 256], using post-swap values
- ct[k]=pt[k] XOR pad
REQ-021 All index arithmetic SHALL be 8-bit and wrap mod 256. The k counter SHALL be 9 bits so that L=255 terminates without wrapping.
REQ-022 When i=j, the swap SHALL leave S unchanged, i.e. it SHALL use the value read, not a stale one.
REQ-023 At most one write per memory SHALL occur per cycle. ct_wren SHALL pulse exactly L+1 times per run, at addresses 0..L in ascending order.
REQ-024 The block SHALL never write pt memory and SHALL never read ct memory.
REQ-025 DONE SHALL last one cycle with all wren=0, then move to IDLE with rdy=1.
REQ-026 Total latency from en to rdy SHALL be bounded by 256 + 256*4 + 2 + L*6 + 4 cycles.

Reset
REQ-027 rst=1 SHALL force IDLE on the next edge with these values:
- rdy=1
- s_wren=0, ct_wren=0
- s_addr=0, pt_addr=0, ct_addr=0
- s_wrdata=0, ct_wrdata=0
- i=j=k=L=0
- latched key=0
REQ-028 rst asserted mid-operation SHALL abort the run with no further writes. A subsequent en SHALL restart from INIT.
REQ-029 en sampled in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-030 key=24'h4B6579, pt="Plaintext" (L=9) -> ct = 09 BB F3 16 E8 D9 40 AF 0A D3, and rdy rises within the REQ-026 bound.
REQ-031 L=0, any key -> exactly one ct write (addr 0, data 00); S holds the KSA permutation; rdy returns high.
REQ-032 Round-trip: key=24'h1E4600, random L=255 pt -> encrypt, copy ct into pt memory, encrypt again -> output equals the original pt byte-for-byte, and no address wraps past 255.
REQ-033 en pulsed every cycle during a run with a different key -> output matches a single run with the first key, and rdy stays 0 until DONE.
REQ-034 rst pulsed for 1 cycle in the middle of PRGA -> all wren=0 from the next cycle and rdy=1. A new en with key=24'h4B6579 then reproduces REQ-030 exactly.
REQ-035 Bench SHALL assert at most one s_wren per cycle, ct_wren count = L+1, and a scoreboard check of S contents after KSA against a reference model.
